reuleaux: RTL and testbench



---
 rtl/vga_pkg.sv | 54 +++++
 rtl/circle_core.sv | 89 ++++++++
 rtl/reuleaux.sv | 135 +++++++++++++
 tb/tb_reuleaux.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA framebuffer definitions: screen geometry, coordinate type,
// fixed-point sqrt(3) fractions, FSM states and octant point helper.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COORD_W  = 12;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  // d*sqrt(3)/6 ~= d*37/128, d*sqrt(3)/3 ~= d*74/128
  localparam logic [7:0] SQRT3_6_NUM = 8'd37;
  localparam logic [7:0] SQRT3_3_NUM = 8'd74;
  localparam int         FRAC_SHIFT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_OCT,
    ST_DONE
  } state_t;

  // (d * num) >> FRAC_SHIFT, as a non-negative coordinate
  function automatic coord_t scale_frac(input logic [7:0] d, input logic [7:0] num);
    logic [15:0] prod;
    prod = {8'd0, d} * {8'd0, num};
    return coord_t'(prod >> FRAC_SHIFT);
  endfunction

  // One of the eight symmetric points of a circle octant offset (ox, oy)
  function automatic point_t octant_point(input coord_t x, input coord_t y,
                                          input coord_t ox, input coord_t oy,
                                          input logic [2:0] o);
    point_t p;
    case (o)
      3'd0:    begin p.x = x + ox; p.y = y + oy; end
      3'd1:    begin p.x = x + oy; p.y = y + ox; end
      3'd2:    begin p.x = x - ox; p.y = y + oy; end
      3'd3:    begin p.x = x - oy; p.y = y + ox; end
      3'd4:    begin p.x = x - ox; p.y = y - oy; end
      3'd5:    begin p.x = x - oy; p.y = y - ox; end
      3'd6:    begin p.x = x + ox; p.y = y - oy; end
      default: begin p.x = x + oy; p.y = y - ox; end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/circle_core.sv
// Bresenham circle stepper: one registered candidate point per clock,
// eight octant points per (ox, oy) step. A load pulse restarts it.
module circle_core
  import vga_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  coord_t cx,
  input  coord_t cy,
  input  coord_t r,
  output coord_t cand_x,
  output coord_t cand_y,
  output logic   valid,
  output logic   last
);

  coord_t     ox, oy, crit;
  coord_t     ctr_x, ctr_y;
  logic [2:0] oct;
  logic       active;

  coord_t     ox_n, oy_n, crit_n;
  logic       more_n;
  point_t     cur, first;

  // Next Bresenham step and the candidate for the current octant
  always_comb begin
    oy_n = oy + coord_t'(1);
    if (crit[COORD_W-1] || (crit == '0)) begin
      ox_n   = ox;
      crit_n = crit + (oy_n <<< 1) + coord_t'(1);
    end else begin
      ox_n   = ox - coord_t'(1);
      crit_n = crit + ((oy_n - ox_n) <<< 1) + coord_t'(1);
    end
    more_n = (oy_n <= ox_n);
    cur    = octant_point(ctr_x, ctr_y, ox, oy, oct);
    first  = octant_point(cx, cy, r, '0, 3'd0);
  end

  // The load cycle itself registers octant 0; oct then points at the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox     <= '0;
      oy     <= '0;
      crit   <= '0;
      ctr_x  <= '0;
      ctr_y  <= '0;
      oct    <= '0;
      active <= 1'b0;
      cand_x <= '0;
      cand_y <= '0;
      valid  <= 1'b0;
      last   <= 1'b0;
    end else if (load) begin
      ctr_x  <= cx;
      ctr_y  <= cy;
      ox     <= r;
      oy     <= '0;
      crit   <= coord_t'(1) - r;
      oct    <= 3'd1;
      active <= 1'b1;
      cand_x <= first.x;
      cand_y <= first.y;
      valid  <= 1'b1;
      last   <= 1'b0;
    end else if (active) begin
      cand_x <= cur.x;
      cand_y <= cur.y;
      valid  <= 1'b1;
      oct    <= oct + 3'd1;
      last   <= 1'b0;
      if (oct == 3'd7) begin
        ox   <= ox_n;
        oy   <= oy_n;
        crit <= crit_n;
        if (!more_n) begin
          active <= 1'b0;
          last   <= 1'b1;
        end
      end
    end else begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/reuleaux.sv
// Reuleaux triangle outline plotter: three clipped, arc-filtered circles
// centred on the corners of an equilateral triangle.
module reuleaux
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] diameter,
  input  logic       start,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  state_t     state;
  logic [2:0] colour_r;
  logic [7:0] cx_r;
  logic [6:0] cy_r;
  logic [7:0] d_r;
  logic [1:0] circ;
  coord_t     c1x, c1y, c2x, c3x, c3y;

  coord_t     cx_e, cy_e, half_d, h6, h3, radius;
  coord_t     core_cx, core_cy;
  coord_t     cand_x, cand_y;
  logic       core_valid, core_last, core_load;
  logic       on_screen, arc_ok;

  // Corner arithmetic operands and the circle centre for the active arc
  always_comb begin
    cx_e      = coord_t'(cx_r);
    cy_e      = coord_t'(cy_r);
    half_d    = coord_t'(d_r >> 1);
    h6        = scale_frac(d_r, SQRT3_6_NUM);
    h3        = scale_frac(d_r, SQRT3_3_NUM);
    radius    = coord_t'(d_r);
    core_load = (state == ST_LOAD);
    case (circ)
      2'd0:    begin core_cx = c1x; core_cy = c1y; end
      2'd1:    begin core_cx = c2x; core_cy = c1y; end
      default: begin core_cx = c3x; core_cy = c3y; end
    endcase
  end

  circle_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load),
    .cx     (core_cx),
    .cy     (core_cy),
    .r      (radius),
    .cand_x (cand_x),
    .cand_y (cand_y),
    .valid  (core_valid),
    .last   (core_last)
  );

  // Screen clipping and per-arc filter on the registered candidate
  always_comb begin
    on_screen = !cand_x[COORD_W-1] && (cand_x <= coord_t'(SCREEN_W - 1)) &&
                !cand_y[COORD_W-1] && (cand_y <= coord_t'(SCREEN_H - 1));
    case (circ)
      2'd0:    arc_ok = (cand_x <= c3x) && (cand_y <= c1y);
      2'd1:    arc_ok = (cand_x >= c3x) && (cand_y <= c1y);
      default: arc_ok = (cand_y >= c1y);
    endcase
    vga_plot   = core_valid && on_screen && arc_ok;
    vga_x      = cand_x[7:0];
    vga_y      = cand_y[6:0];
    vga_colour = colour_r;
    done       = (state == ST_DONE);
  end

  // Handshake FSM, input capture and corner registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      colour_r <= '0;
      cx_r     <= '0;
      cy_r     <= '0;
      d_r      <= '0;
      circ     <= '0;
      c1x      <= '0;
      c1y      <= '0;
      c2x      <= '0;
      c3x      <= '0;
      c3y      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            colour_r <= colour;
            cx_r     <= centre_x;
            cy_r     <= centre_y;
            d_r      <= diameter;
            circ     <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          c1x   <= cx_e + half_d;
          c1y   <= cy_e + h6;
          c2x   <= cx_e - half_d;
          c3x   <= cx_e;
          c3y   <= cy_e - h3;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          state <= ST_OCT;
        end
        ST_OCT: begin
          // last is seen while the final candidate is on the outputs
          if (core_last) begin
            if (circ == 2'd2) begin
              state <= ST_DONE;
            end else begin
              circ  <= circ + 2'd1;
              state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          if (!start) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reuleaux.sv
// Self-checking bench for reuleaux: directed and random draws compared
// against a pixel-list model built directly from the drawing rules.
module tb_reuleaux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] colour = '0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] diameter = '0;
  logic       start = 1'b0;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int n_assert = 0;
  int n_fail   = 0;

  int exp_x[$], exp_y[$], exp_c[$];
  int exp_done;
  int got_x[$], got_y[$], got_c[$], got_col[$];
  int got_done;

  reuleaux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .colour     (colour),
    .centre_x   (centre_x),
    .centre_y   (centre_y),
    .diameter   (diameter),
    .start      (start),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Expected plotted pixels with the cycle (after start is sampled) each appears in
  task automatic model(input int cx, input int cy, input int d);
    int kx[3], ky[3];
    int dx[8], dy[8];
    int ox, oy, crit, px, py, cyc;
    bit keep;
    exp_x.delete(); exp_y.delete(); exp_c.delete();
    kx[0] = cx + d / 2; ky[0] = cy + (d * 37) / 128;
    kx[1] = cx - d / 2; ky[1] = ky[0];
    kx[2] = cx;         ky[2] = cy - (d * 74) / 128;
    cyc = 3;
    for (int c = 0; c < 3; c++) begin
      ox = d; oy = 0; crit = 1 - d;
      while (oy <= ox) begin
        dx = '{ox, oy, -ox, -oy, -ox, -oy, ox, oy};
        dy = '{oy, ox, oy, ox, -oy, -ox, -oy, -ox};
        for (int k = 0; k < 8; k++) begin
          px = kx[c] + dx[k];
          py = ky[c] + dy[k];
          keep = (px >= 0) && (px <= 159) && (py >= 0) && (py <= 119);
          if (c == 0)      keep = keep && (px <= kx[2]) && (py <= ky[0]);
          else if (c == 1) keep = keep && (px >= kx[2]) && (py <= ky[0]);
          else             keep = keep && (py >= ky[0]);
          if (keep) begin
            exp_x.push_back(px); exp_y.push_back(py); exp_c.push_back(cyc);
          end
          cyc++;
        end
        oy++;
        if (crit <= 0) crit += 2 * oy + 1;
        else begin
          ox--;
          crit += 2 * (oy - ox) + 1;
        end
      end
      if (c < 2) cyc++;
    end
    exp_done = cyc;
  endtask

  // Raise start with the given inputs and log plots until done (bounded)
  task automatic run_draw(input int col, input int cx, input int cy, input int d,
                          input int change_at);
    colour = 3'(col); centre_x = 8'(cx); centre_y = 7'(cy); diameter = 8'(d);
    start = 1'b1;
    got_x.delete(); got_y.delete(); got_c.delete(); got_col.delete();
    got_done = -1;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      @(posedge clk); #1;
      if (cyc == change_at) begin
        colour   = 3'($urandom);
        centre_x = 8'($urandom);
        centre_y = 7'($urandom);
        diameter = 8'($urandom);
      end
      if (vga_plot === 1'b1) begin
        got_x.push_back(int'(vga_x)); got_y.push_back(int'(vga_y));
        got_c.push_back(cyc); got_col.push_back(int'(vga_colour));
      end
      if (done === 1'b1) begin
        got_done = cyc;
        break;
      end
    end
  endtask

  task automatic check_draw(input string tag, input int col);
    int bad_seq, bad_col, n;
    bad_seq = 0; bad_col = 0;
    n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
    for (int i = 0; i < n; i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i] || got_c[i] != exp_c[i]) bad_seq++;
    foreach (got_col[i]) if (got_col[i] != col) bad_col++;
    chk({tag, "_done_cycle"}, got_done, exp_done);
    chk({tag, "_plot_count"}, got_x.size(), exp_x.size());
    chk({tag, "_pixel_seq_errors"}, bad_seq, 0);
    chk({tag, "_colour_errors"}, bad_col, 0);
  endtask

  task automatic release_start(input string tag);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    int bad;

    // Reset state with the clock running
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal draw
    model(80, 60, 80);
    run_draw(2, 80, 60, 80, 0);
    check_draw("nominal", 2);
    chk("nominal_first_x", got_x[0], 40);
    chk("nominal_first_y", got_y[0], 83);
    chk("nominal_first_colour", got_col[0], 2);

    // Hold start after done: done stays, nothing plotted
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || vga_plot !== 1'b0) bad++;
    end
    chk("hold_errors", bad, 0);
    release_start("hold");

    // Redraw reproduces the identical sequence
    run_draw(2, 80, 60, 80, 0);
    check_draw("redraw", 2);
    release_start("redraw");

    // Clipping near the bottom-right corner
    model(150, 110, 80);
    run_draw(7, 150, 110, 80, 0);
    check_draw("clip", 7);
    bad = 0;
    foreach (got_x[i]) if (got_x[i] > 159 || got_y[i] > 119) bad++;
    chk("clip_offscreen", bad, 0);
    release_start("clip");

    // Zero diameter: the centre pixel only
    model(10, 10, 0);
    run_draw(4, 10, 10, 0, 0);
    check_draw("d0", 4);
    bad = 0;
    foreach (got_x[i]) if (got_x[i] != 10 || got_y[i] != 10) bad++;
    chk("d0_not_centre", bad, 0);
    chk("d0_count", got_x.size(), 24);
    release_start("d0");

    // Inputs changed mid-draw are ignored
    model(80, 60, 80);
    run_draw(5, 80, 60, 80, 50);
    check_draw("stable", 5);
    release_start("stable");

    // Random draws
    for (int t = 0; t < 4; t++) begin
      int rc, rx, ry, rd;
      rc = $urandom_range(0, 7);
      rx = $urandom_range(0, 200);
      ry = $urandom_range(0, 127);
      rd = $urandom_range(0, 70);
      model(rx, ry, rd);
      run_draw(rc, rx, ry, rd, 0);
      check_draw($sformatf("rand%0d", t), rc);
      release_start($sformatf("rand%0d", t));
    end

    // Asynchronous reset in the middle of a draw
    colour = 3'd6; centre_x = 8'd80; centre_y = 7'd60; diameter = 8'd80;
    start = 1'b1;
    repeat (60) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_done", done, 0);
    chk("midrst_plot", vga_plot, 0);
    chk("midrst_x", vga_x, 0);
    chk("midrst_y", vga_y, 0);
    chk("midrst_colour", vga_colour, 0);
    start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery after the aborted draw
    model(40, 50, 30);
    run_draw(1, 40, 50, 30, 0);
    check_draw("recover", 1);
    release_start("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
